// File: rtl/atualiza_tabuleiro_pkg.sv
// Shared types and tables for the ultimate tic-tac-toe board writer.
package jogo_pkg;

  typedef logic [1:0] cel_t;

  localparam cel_t VAZIA = 2'b00;
  localparam cel_t X     = 2'b01;
  localparam cel_t O     = 2'b10;
  localparam cel_t VELHA = 2'b11;

  // The 8 winning lines of a 3x3 board, row-major cell indices
  localparam logic [3:0] LINHAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [2:0] {
    OCIOSO, VALIDA, GRAVA_MICRO, VERIFICA_MICRO,
    GRAVA_MACRO, VERIFICA_MACRO, FIM, INVALIDA
  } estado_t;

endpackage

// File: rtl/atualiza_tabuleiro_if.sv
// Move request / macro read / status bundle of the board writer.
interface atualiza_tabuleiro_if;
  import jogo_pkg::*;

  logic       jogar;
  logic [3:0] end_macro;
  logic [3:0] end_micro;
  logic       jogador;
  logic [3:0] addr_leitura;
  cel_t       estado_leitura;
  logic       ocupado;
  logic       pronto;
  logic       jogada_invalida;
  cel_t       resultado_micro;
  logic       fim_jogo;
  cel_t       vencedor;

  modport master (
    output jogar, end_macro, end_micro, jogador, addr_leitura,
    input  estado_leitura, ocupado, pronto, jogada_invalida,
           resultado_micro, fim_jogo, vencedor
  );

  modport slave (
    input  jogar, end_macro, end_micro, jogador, addr_leitura,
    output estado_leitura, ocupado, pronto, jogada_invalida,
           resultado_micro, fim_jogo, vencedor
  );
endinterface

// File: rtl/atualiza_tabuleiro_checa_linha.sv
// One line of three cells matches when every cell holds the given code.
module checa_linha
  import jogo_pkg::*;
(
  input  cel_t a,
  input  cel_t b,
  input  cel_t c,
  input  cel_t codigo,
  output logic casa
);
  assign casa = (a == codigo) && (b == codigo) && (c == codigo);
endmodule

// File: rtl/atualiza_tabuleiro.sv
// Board writer: validates a move, writes the micro cell, scans the micro
// board, writes the macro result, then scans the macro board for game end.
module atualiza_tabuleiro
  import jogo_pkg::*;
(
  input logic clock,
  input logic reset,
  atualiza_tabuleiro_if.slave bus
);

  estado_t    est_q, est_d;
  cel_t       micro_q [9][9];
  cel_t       micro_d [9][9];
  cel_t       macro_q [9];
  cel_t       macro_d [9];
  logic [3:0] mac_q, mac_d, mic_q, mic_d;
  cel_t       cod_q, cod_d;
  logic [2:0] lin_q, lin_d;
  logic       vit_q, vit_d;
  logic       pronto_q, pronto_d, inv_q, inv_d, fim_q, fim_d;
  cel_t       res_q, res_d, venc_q, venc_d;

  logic [3:0] mac_i, mic_i;
  cel_t       c0, c1, c2;
  logic       casa, micro_cheio, macro_cheio;

  // Out-of-range addresses are clamped so array reads stay in bounds;
  // such moves are rejected before any write happens.
  assign mac_i = (mac_q > 4'd8) ? 4'd0 : mac_q;
  assign mic_i = (mic_q > 4'd8) ? 4'd0 : mic_q;

  // One line checker shared by both scans; the state selects the board
  always_comb begin
    if (est_q == VERIFICA_MICRO) begin
      c0 = micro_q[mac_i][LINHAS[lin_q][0]];
      c1 = micro_q[mac_i][LINHAS[lin_q][1]];
      c2 = micro_q[mac_i][LINHAS[lin_q][2]];
    end else begin
      c0 = macro_q[LINHAS[lin_q][0]];
      c1 = macro_q[LINHAS[lin_q][1]];
      c2 = macro_q[LINHAS[lin_q][2]];
    end
  end

  checa_linha u_linha (.a(c0), .b(c1), .c(c2), .codigo(cod_q), .casa(casa));

  // Fullness of the addressed micro board and of the macro board
  always_comb begin
    micro_cheio = 1'b1;
    macro_cheio = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (micro_q[mac_i][4'(i)] == VAZIA) micro_cheio = 1'b0;
      if (macro_q[4'(i)] == VAZIA)        macro_cheio = 1'b0;
    end
  end

  // Next-state logic of the move FSM and the board memories
  always_comb begin
    est_d    = est_q;
    micro_d  = micro_q;
    macro_d  = macro_q;
    mac_d    = mac_q;
    mic_d    = mic_q;
    cod_d    = cod_q;
    lin_d    = lin_q;
    vit_d    = vit_q;
    fim_d    = fim_q;
    venc_d   = venc_q;
    pronto_d = 1'b0;
    inv_d    = 1'b0;
    res_d    = VAZIA;
    case (est_q)
      OCIOSO: if (bus.jogar) begin
        mac_d = bus.end_macro;
        mic_d = bus.end_micro;
        cod_d = bus.jogador ? O : X;
        est_d = VALIDA;
      end
      VALIDA: begin
        if (mac_q > 4'd8 || mic_q > 4'd8 || macro_q[mac_i] != VAZIA ||
            micro_q[mac_i][mic_i] != VAZIA || fim_q)
          est_d = INVALIDA;
        else
          est_d = GRAVA_MICRO;
      end
      GRAVA_MICRO: begin
        micro_d[mac_i][mic_i] = cod_q;
        lin_d = 3'd0;
        vit_d = 1'b0;
        est_d = VERIFICA_MICRO;
      end
      VERIFICA_MICRO: begin
        if (casa) vit_d = 1'b1;
        lin_d = lin_q + 3'd1;
        if (lin_q == 3'd7) est_d = GRAVA_MACRO;
      end
      GRAVA_MACRO: begin
        macro_d[mac_i] = vit_q ? cod_q : (micro_cheio ? VELHA : VAZIA);
        lin_d = 3'd0;
        vit_d = 1'b0;
        est_d = VERIFICA_MACRO;
      end
      VERIFICA_MACRO: begin
        if (casa) vit_d = 1'b1;
        lin_d = lin_q + 3'd1;
        if (lin_q == 3'd7) est_d = FIM;
      end
      FIM: begin
        pronto_d = 1'b1;
        res_d    = macro_q[mac_i];
        if (vit_q) begin
          fim_d  = 1'b1;
          venc_d = cod_q;
        end else if (macro_cheio) begin
          fim_d  = 1'b1;
          venc_d = VELHA;
        end
        est_d = OCIOSO;
      end
      INVALIDA: begin
        inv_d = 1'b1;
        est_d = OCIOSO;
      end
      default: est_d = OCIOSO;
    endcase
  end

  // State registers; reset wipes both boards and the game result
  always_ff @(posedge clock) begin
    if (reset) begin
      est_q    <= OCIOSO;
      micro_q  <= '{default: VAZIA};
      macro_q  <= '{default: VAZIA};
      mac_q    <= '0;
      mic_q    <= '0;
      cod_q    <= VAZIA;
      lin_q    <= '0;
      vit_q    <= 1'b0;
      pronto_q <= 1'b0;
      inv_q    <= 1'b0;
      res_q    <= VAZIA;
      fim_q    <= 1'b0;
      venc_q   <= VAZIA;
    end else begin
      est_q    <= est_d;
      micro_q  <= micro_d;
      macro_q  <= macro_d;
      mac_q    <= mac_d;
      mic_q    <= mic_d;
      cod_q    <= cod_d;
      lin_q    <= lin_d;
      vit_q    <= vit_d;
      pronto_q <= pronto_d;
      inv_q    <= inv_d;
      res_q    <= res_d;
      fim_q    <= fim_d;
      venc_q   <= venc_d;
    end
  end

  assign bus.estado_leitura  = (bus.addr_leitura > 4'd8) ? VAZIA : macro_q[bus.addr_leitura];
  assign bus.ocupado         = (est_q != OCIOSO);
  assign bus.pronto          = pronto_q;
  assign bus.jogada_invalida = inv_q;
  assign bus.resultado_micro = res_q;
  assign bus.fim_jogo        = fim_q;
  assign bus.vencedor        = venc_q;

endmodule

// File: tb/tb_atualiza_tabuleiro.sv
// Directed bench for the ultimate tic-tac-toe board writer.
module tb_atualiza_tabuleiro;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  atualiza_tabuleiro_if bus ();
  atualiza_tabuleiro dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic do_reset;
    reset = 1'b1;
    bus.jogar = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Issue one move; inputs are scrambled after acceptance to exercise latching
  task automatic mover(input logic [3:0] mac, input logic [3:0] mic, input logic jog,
                       output int lat_p, output int lat_i, output logic [1:0] res,
                       output logic fim, output logic [1:0] venc, output logic ocup1);
    lat_p = 0; lat_i = 0; res = 2'bxx; fim = 1'bx; venc = 2'bxx;
    bus.end_macro = mac; bus.end_micro = mic; bus.jogador = jog; bus.jogar = 1'b1;
    @(posedge clock); #1;
    bus.jogar = 1'b0; bus.end_macro = 4'hf; bus.end_micro = 4'hf; bus.jogador = ~jog;
    ocup1 = bus.ocupado;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.pronto) begin
        lat_p = n; res = bus.resultado_micro; fim = bus.fim_jogo; venc = bus.vencedor;
        break;
      end
      if (bus.jogada_invalida) begin
        lat_i = n; fim = bus.fim_jogo; venc = bus.vencedor;
        break;
      end
    end
  endtask

  task automatic ler(input logic [3:0] a, output logic [1:0] v);
    @(negedge clock);
    bus.addr_leitura = a;
    #1 v = bus.estado_leitura;
  endtask

  task automatic test_reset;
    logic [1:0] v;
    do_reset;
    n_cmp++; if (bus.ocupado !== 1'b0) begin n_err++; $display("FAIL rst_ocupado: got %b want 0", bus.ocupado); end
    n_cmp++; if (bus.pronto !== 1'b0) begin n_err++; $display("FAIL rst_pronto: got %b want 0", bus.pronto); end
    n_cmp++; if (bus.jogada_invalida !== 1'b0) begin n_err++; $display("FAIL rst_inv: got %b want 0", bus.jogada_invalida); end
    n_cmp++; if (bus.resultado_micro !== 2'b00) begin n_err++; $display("FAIL rst_res: got %b want 00", bus.resultado_micro); end
    n_cmp++; if (bus.fim_jogo !== 1'b0) begin n_err++; $display("FAIL rst_fim: got %b want 0", bus.fim_jogo); end
    n_cmp++; if (bus.vencedor !== 2'b00) begin n_err++; $display("FAIL rst_venc: got %b want 00", bus.vencedor); end
    for (int a = 0; a < 10; a++) begin
      ler(4'(a), v);
      n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL rst_macro[%0d]: got %b want 00", a, v); end
    end
  endtask

  task automatic test_first_move;
    int lp, li; logic [1:0] r, vn, v; logic f, oc;
    mover(4'd4, 4'd0, 1'b0, lp, li, r, f, vn, oc);
    n_cmp++; if (oc !== 1'b1) begin n_err++; $display("FAIL first_ocupado: got %b want 1", oc); end
    n_cmp++; if (lp !== 20) begin n_err++; $display("FAIL first_lat: got %0d want 20", lp); end
    n_cmp++; if (li !== 0) begin n_err++; $display("FAIL first_inv: got %0d want 0", li); end
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL first_res: got %b want 00", r); end
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL first_fim: got %b want 0", f); end
    ler(4'd4, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL first_macro4: got %b want 00", v); end
  endtask

  task automatic test_micro_win;
    logic [3:0] ma [5] = '{4'd2, 4'd0, 4'd2, 4'd0, 4'd2};
    logic [3:0] mi [5] = '{4'd0, 4'd0, 4'd4, 4'd1, 4'd8};
    logic       jg [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lp, li; logic [1:0] r, vn, v, er; logic f, oc;
    for (int k = 0; k < 5; k++) begin
      mover(ma[k], mi[k], jg[k], lp, li, r, f, vn, oc);
      er = (k == 4) ? 2'b01 : 2'b00;
      n_cmp++; if (lp !== 20) begin n_err++; $display("FAIL win_lat[%0d]: got %0d want 20", k, lp); end
      n_cmp++; if (r !== er) begin n_err++; $display("FAIL win_res[%0d]: got %b want %b", k, r, er); end
    end
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL win_fim: got %b want 0", f); end
    ler(4'd2, v);
    n_cmp++; if (v !== 2'b01) begin n_err++; $display("FAIL win_macro2: got %b want 01", v); end
    ler(4'd0, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL win_macro0: got %b want 00", v); end
  endtask

  task automatic test_invalid;
    logic [3:0] ma [4] = '{4'd4, 4'd2, 4'd3, 4'd9};
    logic [3:0] mi [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    logic       jg [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int lp, li; logic [1:0] r, vn, v; logic f, oc;
    for (int k = 0; k < 4; k++) begin
      mover(ma[k], mi[k], jg[k], lp, li, r, f, vn, oc);
      n_cmp++; if (li !== 2) begin n_err++; $display("FAIL inv_lat[%0d]: got %0d want 2", k, li); end
      n_cmp++; if (lp !== 0) begin n_err++; $display("FAIL inv_pronto[%0d]: got %0d want 0", k, lp); end
    end
    ler(4'd4, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL inv_macro4: got %b want 00", v); end
    ler(4'd2, v);
    n_cmp++; if (v !== 2'b01) begin n_err++; $display("FAIL inv_macro2: got %b want 01", v); end
    mover(4'd4, 4'd1, 1'b1, lp, li, r, f, vn, oc);
    n_cmp++; if (lp !== 20) begin n_err++; $display("FAIL inv_after_lat: got %0d want 20", lp); end
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL inv_after_res: got %b want 00", r); end
  endtask

  // Board X O X / X O O / O X X has no line: each of macros 0,1,2 ties
  task automatic test_velha;
    logic [8:0] pat = 9'b001110010;
    int lp, li; logic [1:0] r, vn, v, er; logic f, oc;
    do_reset;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 9; k++) begin
        mover(4'(m), 4'(k), pat[k], lp, li, r, f, vn, oc);
        er = (k == 8) ? 2'b11 : 2'b00;
        n_cmp++; if (lp !== 20) begin n_err++; $display("FAIL velha_lat[%0d][%0d]: got %0d want 20", m, k, lp); end
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL velha_res[%0d][%0d]: got %b want %b", m, k, r, er); end
      end
    end
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL velha_fim: got %b want 0", f); end
    n_cmp++; if (vn !== 2'b00) begin n_err++; $display("FAIL velha_venc: got %b want 00", vn); end
    for (int a = 0; a < 3; a++) begin
      ler(4'(a), v);
      n_cmp++; if (v !== 2'b11) begin n_err++; $display("FAIL velha_macro[%0d]: got %b want 11", a, v); end
    end
    ler(4'd3, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL velha_macro3: got %b want 00", v); end
    ler(4'd9, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL velha_addr9: got %b want 00", v); end
    ler(4'd15, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL velha_addr15: got %b want 00", v); end
  endtask

  task automatic test_o_win;
    logic [3:0] ms [3] = '{4'd6, 4'd4, 4'd2};
    int lp, li; logic [1:0] r, vn, v, er, ev; logic f, oc, ef;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        mover(ms[i], 4'(k), 1'b1, lp, li, r, f, vn, oc);
        er = (k == 2) ? 2'b10 : 2'b00;
        ef = (i == 2 && k == 2);
        ev = ef ? 2'b10 : 2'b00;
        n_cmp++; if (lp !== 20) begin n_err++; $display("FAIL owin_lat[%0d][%0d]: got %0d want 20", i, k, lp); end
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL owin_res[%0d][%0d]: got %b want %b", i, k, r, er); end
        n_cmp++; if (f !== ef) begin n_err++; $display("FAIL owin_fim[%0d][%0d]: got %b want %b", i, k, f, ef); end
        n_cmp++; if (vn !== ev) begin n_err++; $display("FAIL owin_venc[%0d][%0d]: got %b want %b", i, k, vn, ev); end
      end
    end
    mover(4'd0, 4'd0, 1'b0, lp, li, r, f, vn, oc);
    n_cmp++; if (li !== 2) begin n_err++; $display("FAIL owin_after_inv: got %0d want 2", li); end
    n_cmp++; if (f !== 1'b1) begin n_err++; $display("FAIL owin_after_fim: got %b want 1", f); end
    n_cmp++; if (vn !== 2'b10) begin n_err++; $display("FAIL owin_after_venc: got %b want 10", vn); end
    ler(4'd6, v);
    n_cmp++; if (v !== 2'b10) begin n_err++; $display("FAIL owin_macro6: got %b want 10", v); end
    ler(4'd0, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL owin_macro0: got %b want 00", v); end
  endtask

  task automatic test_reset_mid;
    int pulses; logic [1:0] v;
    do_reset;
    bus.end_macro = 4'd5; bus.end_micro = 4'd3; bus.jogador = 1'b0; bus.jogar = 1'b1;
    @(posedge clock); #1 bus.jogar = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    n_cmp++; if (bus.ocupado !== 1'b0) begin n_err++; $display("FAIL mid_ocupado: got %b want 0", bus.ocupado); end
    pulses = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (bus.pronto || bus.jogada_invalida) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mid_pulses: got %0d want 0", pulses); end
    ler(4'd5, v);
    n_cmp++; if (v !== 2'b00) begin n_err++; $display("FAIL mid_macro5: got %b want 00", v); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.end_macro = 4'd5; bus.end_micro = 4'd3; bus.jogador = 1'b0;
    bus.jogar = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (bus.ocupado !== 1'b0) begin n_err++; $display("FAIL b2b_rst_dom: got %b want 0", bus.ocupado); end
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (bus.ocupado !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %b want 1", bus.ocupado); end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.pronto) begin lat = n; break; end
    end
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL b2b_lat: got %0d want 20", lat); end
    @(posedge clock); #1;
    n_cmp++; if (bus.ocupado !== 1'b1) begin n_err++; $display("FAIL b2b_restart: got %b want 1", bus.ocupado); end
    bus.jogar = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (bus.jogada_invalida) begin lat = n; break; end
    end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL b2b_inv_lat: got %0d want 2", lat); end
  endtask

  initial begin
    bus.jogar = 1'b0; bus.end_macro = '0; bus.end_micro = '0;
    bus.jogador = 1'b0; bus.addr_leitura = '0;
    test_reset;
    test_first_move;
    test_micro_win;
    test_invalid;
    test_velha;
    test_o_win;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
